// File: rtl/rock_pkg.sv
// rock_pkg: shared types and constants for the rock scheduler.
//   slot_state_t    per-rock life-cycle state
//   SCORE_1..3      points awarded for 1, 2 and 3+ crushed enemies
//   CRUSH_MAX       saturation value of the per-slot crush counter
//   crush_to_score  maps a crush count to its point value
package rock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_FALLING,
    ST_SCORE,
    ST_DONE
  } slot_state_t;

  localparam int unsigned SCORE_1   = 1000;
  localparam int unsigned SCORE_2   = 2500;
  localparam int unsigned SCORE_3   = 4000;
  localparam int unsigned CRUSH_MAX = 3;

  function automatic int unsigned crush_to_score(input int unsigned count);
    int unsigned pts;
    case (count)
      0:       pts = 0;
      1:       pts = SCORE_1;
      2:       pts = SCORE_2;
      default: pts = SCORE_3;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       request vector, one bit per requester
//   ptr       index where the search starts (highest priority this cycle)
//   grant     one-hot grant, all zero when nothing requests
//   grant_id  binary index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic           found;
  int             sum;

  // Rotate the requests so that bit 0 of 'rotated' is the slot at ptr;
  // the first set bit of 'rotated' is then the round-robin winner.
  assign doubled = {req, req} >> ptr;
  assign rotated = doubled[N-1:0];

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = 0;
    for (int j = 0; j < N; j++) begin
      if (!found && rotated[j]) begin
        found = 1'b1;
        sum   = int'(ptr) + j;
        if (sum >= N) sum = sum - N;
      end
    end
    if (found) begin
      grant_id = ID_W'(sum);
      grant    = {{(N-1){1'b0}}, 1'b1} << grant_id;
    end
  end

endmodule

// File: rtl/rock_scheduler.sv
// rock_scheduler: frame-rate sequencer for the rock instances of a level.
//   frame_clk      frame clock, everything advances once per frame
//   Reset          asynchronous, active-high
//   level_start    one-frame pulse (re)starting every slot
//   slot_enable    rocks present in the level, sampled on level_start
//   falling        per-rock falling flag
//   delete_rock    per-rock landed/killed flag
//   crush_hit      per-rock enemy-struck pulse
//   score_ready    score adder accepts the current request
//   rock_reset     reset to each rock instance
//   rock_visible   rock is drawn
//   score_valid / score_amount / score_rock_id   score request to the adder
//   bonus_spawn    one-frame pulse after the second drop of a level
//   all_done       every enabled slot has finished
//
// Score handshake: a request is presented with score_valid=1 and its
// amount/id held stable until a frame where score_valid and score_ready
// are both high; that frame completes the transfer and score_valid is
// low for at least the following frame.
module rock_scheduler
  import rock_pkg::*;
#(
  parameter int NUM_ROCKS = 4,
  parameter int SCORE_W   = 14,
  parameter int CRUSH_W   = 2,
  localparam int ID_W     = (NUM_ROCKS > 1) ? $clog2(NUM_ROCKS) : 1
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 level_start,
  input  logic [NUM_ROCKS-1:0] slot_enable,
  input  logic [NUM_ROCKS-1:0] falling,
  input  logic [NUM_ROCKS-1:0] delete_rock,
  input  logic [NUM_ROCKS-1:0] crush_hit,
  input  logic                 score_ready,
  output logic [NUM_ROCKS-1:0] rock_reset,
  output logic [NUM_ROCKS-1:0] rock_visible,
  output logic                 score_valid,
  output logic [SCORE_W-1:0]   score_amount,
  output logic [ID_W-1:0]      score_rock_id,
  output logic                 bonus_spawn,
  output logic                 all_done
);

  slot_state_t          state      [NUM_ROCKS];
  slot_state_t          state_next [NUM_ROCKS];
  logic [CRUSH_W-1:0]   crush      [NUM_ROCKS];
  logic [CRUSH_W-1:0]   crush_next [NUM_ROCKS];
  logic [NUM_ROCKS-1:0] enabled;

  logic [1:0]           drop_cnt;
  logic [1:0]           drop_next;
  logic                 bonus_done;
  logic [ID_W-1:0]      rr_ptr;

  logic [NUM_ROCKS-1:0] score_req;
  logic [NUM_ROCKS-1:0] grant_onehot;
  logic [ID_W-1:0]      grant_id;
  logic                 accept;
  int                   land_cnt;
  int                   drop_sum;

  assign accept = score_valid & score_ready;

  rr_arbiter #(
    .N    (NUM_ROCKS),
    .ID_W (ID_W)
  ) u_score_arb (
    .req      (score_req),
    .ptr      (rr_ptr),
    .grant    (grant_onehot),
    .grant_id (grant_id)
  );

  // State register for the slot FSMs and their crush counters.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_ROCKS; i++) begin
        state[i] <= ST_IDLE;
        crush[i] <= '0;
      end
      enabled <= '0;
    end else begin
      for (int i = 0; i < NUM_ROCKS; i++) begin
        state[i] <= state_next[i];
        crush[i] <= crush_next[i];
      end
      if (level_start) enabled <= slot_enable;
    end
  end

  // Next-state logic for every slot, plus the number of rocks landing
  // this frame (feeds the drop counter).
  always_comb begin
    land_cnt = 0;
    for (int i = 0; i < NUM_ROCKS; i++) begin
      state_next[i] = state[i];
      crush_next[i] = crush[i];
      if (level_start) begin
        state_next[i] = slot_enable[i] ? ST_LOAD : ST_IDLE;
      end else begin
        case (state[i])
          ST_LOAD: begin
            crush_next[i] = '0;
            state_next[i] = ST_ARMED;
          end
          ST_ARMED: begin
            // Killed before it fell: finished, but not a drop.
            if (delete_rock[i])  state_next[i] = ST_DONE;
            else if (falling[i]) state_next[i] = ST_FALLING;
          end
          ST_FALLING: begin
            // A hit in the landing frame still counts.
            if (crush_hit[i] && crush[i] != CRUSH_W'(CRUSH_MAX))
              crush_next[i] = crush[i] + CRUSH_W'(1);
            if (delete_rock[i]) begin
              state_next[i] = ST_SCORE;
              land_cnt      = land_cnt + 1;
            end
          end
          ST_SCORE: begin
            if (crush[i] == '0)
              state_next[i] = ST_DONE;
            else if (accept && score_rock_id == ID_W'(i))
              state_next[i] = ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating drop counter update.
  always_comb begin
    drop_sum  = int'(drop_cnt) + land_cnt;
    drop_next = (drop_sum > 3) ? 2'd3 : 2'(drop_sum);
  end

  // Per-slot outputs decoded from state.
  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < NUM_ROCKS; i++) begin
      rock_reset[i]   = (state[i] == ST_IDLE) || (state[i] == ST_LOAD);
      rock_visible[i] = (state[i] == ST_ARMED) || (state[i] == ST_FALLING);
      score_req[i]    = (state[i] == ST_SCORE) && (crush[i] != '0);
      if (enabled[i] && state[i] != ST_DONE) all_done = 1'b0;
    end
  end

  // Score request register, round-robin pointer, drop counter and bonus.
  // A new grant is only taken while score_valid is low, which locks the
  // presented request and forces a gap frame after every acceptance.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      score_valid   <= 1'b0;
      score_amount  <= '0;
      score_rock_id <= '0;
      rr_ptr        <= '0;
      drop_cnt      <= '0;
      bonus_done    <= 1'b0;
      bonus_spawn   <= 1'b0;
    end else if (level_start) begin
      score_valid <= 1'b0;
      rr_ptr      <= '0;
      drop_cnt    <= '0;
      bonus_done  <= 1'b0;
      bonus_spawn <= 1'b0;
    end else begin
      drop_cnt    <= drop_next;
      bonus_spawn <= 1'b0;
      if (!bonus_done && drop_next >= 2'd2) begin
        bonus_spawn <= 1'b1;
        bonus_done  <= 1'b1;
      end
      if (accept) begin
        score_valid <= 1'b0;
        rr_ptr      <= (score_rock_id == ID_W'(NUM_ROCKS - 1)) ? '0
                                                               : score_rock_id + ID_W'(1);
      end else if (!score_valid && (|grant_onehot)) begin
        score_valid   <= 1'b1;
        score_rock_id <= grant_id;
        score_amount  <= SCORE_W'(crush_to_score(32'(crush[grant_id])));
      end
    end
  end

endmodule
